// File: rtl/truth_table_checker.sv
// truth_table_checker
//   Stimulus/response wrapper for a small combinational DUT. It walks every
//   input vector in ascending order and holds each one for SETTLE+1 cycles.
//   At the end of each hold window it samples the DUT output and compares it
//   with EXP_TT[vector]. The run reports a pass flag, the number of mismatches
//   and the index of the first mismatching vector.
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   start            run request, accepted in IDLE or DONE
//   vec_out          DUT input vector (MSB = a, LSB = c)
//   dut_y            DUT output
//   busy             high while a run is in progress
//   done             one-cycle pulse when a run completes
//   pass             last run had no mismatches (held until next start)
//   err_count        mismatches in the current or last run
//   first_fail_valid at least one mismatch seen in this run
//   first_fail_idx   index of the first mismatching vector
module truth_table_checker #(
  parameter int unsigned           N_IN   = 3,
  parameter logic [2**N_IN-1:0]    EXP_TT = 8'h31,
  parameter int unsigned           SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_idx
);

  localparam int unsigned CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN:0]   err_q, err_d;
  logic            pass_q, pass_d;
  logic            ffv_q, ffv_d;
  logic [N_IN-1:0] ffi_q, ffi_d;
  logic            mismatch;

  // Case inequality so an X or Z response is scored as a mismatch.
  assign mismatch = (dut_y !== EXP_TT[vec_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pass_d  = pass_q;
    ffv_d   = ffv_q;
    ffi_d   = ffi_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          ffv_d   = 1'b0;
          ffi_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (cnt_q == CW'(SETTLE)) begin
          cnt_d = '0;
          if (mismatch) begin
            err_d = err_q + 1'b1;
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffi_d = vec_q;
            end
          end
          if (vec_q == '1) begin
            state_d = S_DONE;
            vec_d   = '0;
            // err_d already includes the final compare.
            pass_d  = (err_d == '0);
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign vec_out          = vec_q;
  assign busy             = (state_q == S_RUN);
  assign done             = (state_q == S_DONE);
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

  localparam int unsigned N    = 3;
  localparam int unsigned NV   = 2**N;
  localparam int unsigned SET  = 2;
  localparam logic [7:0]  EXP  = 8'h31;

  // response modes of the modelled DUT
  localparam int M_GOLD  = 0;
  localparam int M_STUCK = 1;
  localparam int M_FAULT = 2;
  localparam int M_X     = 3;

  typedef struct {
    logic [N:0]   err;
    logic         ffv;
    logic [N-1:0] ffi;
    logic         pass;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] vec_out;
  logic         dut_y;
  logic         busy, done, pass;
  logic [N:0]   err_count;
  logic         first_fail_valid;
  logic [N-1:0] first_fail_idx;

  int   mode = M_GOLD;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  truth_table_checker #(.N_IN(N), .EXP_TT(EXP), .SETTLE(SET)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .vec_out          (vec_out),
    .dut_y            (dut_y),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_idx   (first_fail_idx)
  );

  function automatic logic resp(input int m, input int unsigned i);
    logic [7:0] tt;
    tt = EXP;
    case (m)
      M_GOLD:  return tt[i];
      M_STUCK: return 1'b0;
      M_FAULT: return (i == 5) ? ~tt[i] : tt[i];
      default: return 1'bx;
    endcase
  endfunction

  always_comb dut_y = resp(mode, int'(vec_out));

  function automatic exp_t model(input int m);
    exp_t       e;
    logic       r;
    logic [7:0] tt;
    tt    = EXP;
    e.err = '0;
    e.ffv = 1'b0;
    e.ffi = '0;
    for (int unsigned i = 0; i < NV; i++) begin
      r = resp(m, i);
      if (r !== tt[i]) begin
        e.err = e.err + 1'b1;
        if (!e.ffv) begin
          e.ffv = 1'b1;
          e.ffi = N'(i);
        end
      end
    end
    e.pass = (e.err == '0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_vec"},  32'(vec_out), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_err"},  32'(err_count), 32'd0);
    check({tag, "_ffv"},  32'(first_fail_valid), 32'd0);
    check({tag, "_ffi"},  32'(first_fail_idx), 32'd0);
  endtask

  // Called at a negedge with the checker in IDLE or DONE. Asserts start,
  // walks the whole run and scores the result at the done cycle.
  task automatic run(input int m, input bit hold_start);
    exp_t e;
    mode = m;
    sb.push_back(model(m));
    start = 1'b1;
    @(posedge clk);           // edge k
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    check("clr_err",  32'(err_count), 32'd0);
    check("clr_pass", 32'(pass), 32'd0);
    check("clr_ffv",  32'(first_fail_valid), 32'd0);
    check("clr_ffi",  32'(first_fail_idx), 32'd0);
    for (int unsigned i = 0; i < NV; i++) begin
      for (int unsigned c = 0; c <= SET; c++) begin
        check("run_vec",  32'(vec_out), 32'(i));
        check("run_busy", 32'(busy), 32'd1);
        check("run_done", 32'(done), 32'd0);
        @(negedge clk);
      end
    end
    // now after edge k + NV*(SET+1)
    check("end_done", 32'(done), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_vec",  32'(vec_out), 32'd0);
    check("sb_size",  32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("res_err",  32'(err_count), 32'(e.err));
      check("res_pass", 32'(pass), 32'(e.pass));
      check("res_ffv",  32'(first_fail_valid), 32'(e.ffv));
      if (e.ffv) check("res_ffi", 32'(first_fail_idx), 32'(e.ffi));
    end
  endtask

  // After a run ends without restart: done must drop, results must hold.
  task automatic check_idle_after(input int m);
    exp_t e;
    e = model(m);
    @(negedge clk);
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_err",  32'(err_count), 32'(e.err));
    check("idle_pass", 32'(pass), 32'(e.pass));
  endtask

  initial begin
    // reset state
    #2;
    check_reset_vals("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_rst");

    // 1: golden
    run(M_GOLD, 1'b0);
    check("t1_err_const", 32'(err_count), 32'd0);
    check("t1_pass_const", 32'(pass), 32'd1);
    check_idle_after(M_GOLD);

    // 2: stuck-at-0
    run(M_STUCK, 1'b0);
    check("t2_err_const", 32'(err_count), 32'd3);
    check("t2_ffi_const", 32'(first_fail_idx), 32'd0);
    check_idle_after(M_STUCK);

    // 3: single fault at vector 5
    run(M_FAULT, 1'b0);
    check("t3_err_const", 32'(err_count), 32'd1);
    check("t3_ffi_const", 32'(first_fail_idx), 32'd5);
    check_idle_after(M_FAULT);

    // 4: start held high; second run begins at the DONE edge
    run(M_GOLD, 1'b1);
    run(M_STUCK, 1'b0);
    check_idle_after(M_STUCK);

    // 5: reset mid-run while vec_out == 3
    mode  = M_STUCK;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3 * (SET + 1)) @(negedge clk);
    check("t5_vec3", 32'(vec_out), 32'd3);
    check("t5_err_pre", 32'(err_count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("t5_async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("t5_idle");
    run(M_GOLD, 1'b0);
    check_idle_after(M_GOLD);

    // 6: X response
    run(M_X, 1'b0);
    check_idle_after(M_X);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Self-checking stimulus/response stage wrapped around the 3-input combinational `sillyfunction` DUT.
- Drives every input combination in ascending order and holds each one for a settle window.
- Samples the DUT output `y` at the end of each window and compares it against a parameterised truth table.
- Reports pass/fail, the mismatch count and the first failing vector.

Parameters:
- N_IN, 3, number of DUT inputs; the run covers 2^N_IN vectors.
- EXP_TT, 8'h31, expected truth table; bit i is the expected `y` for vector i. Default is y = ~b&~c | a&~b.
- SETTLE, 2, extra cycles each vector is held before sampling; legal range ≥1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request, sampled in IDLE or DONE.
- vec_out  out  N_IN  DUT input vector; bit N_IN-1 = a, bit 0 = c.
- dut_y  in  1  DUT output.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when a run completes.
- pass  out  1  high when the last run had no mismatches; holds until the next start.
- err_count  out  N_IN+1  number of mismatches in the current or last run.
- first_fail_valid  out  1  at least one mismatch has occurred in this run.
- first_fail_idx  out  N_IN  index of the first mismatching vector.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - state=IDLE.
  - vec_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_idx=0.
  - Internal hold counter is cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE: outputs hold. On start=1 at edge k:
    - go to RUN, busy=1, vec_out=0, hold counter=0.
    - clear err_count, pass, first_fail_valid and first_fail_idx.
  - RUN: the hold counter increments every edge. At the edge where counter==SETTLE (a "compare edge"):
    - sample dut_y and compare it with EXP_TT[vec_out] using case equality; X or Z counts as a mismatch.
    - On mismatch: err_count+1. If first_fail_valid=0, set first_fail_valid=1 and first_fail_idx=vec_out.
    - Counter returns to 0.
    - If vec_out < 2^N_IN-1: vec_out+1 and stay in RUN.
    - Otherwise (last vector): go to DONE, busy=0, done=1, vec_out=0, and pass=1 iff the final err_count (including this compare) is 0.
  - DONE: lasts exactly one cycle; done clears on the next edge.
    - If start=1 at that edge, a new run begins exactly as from IDLE, so done and busy never overlap.
    - Otherwise go to IDLE.
- Timing:
  - Vector i is driven from edge k+i*(SETTLE+1) and sampled at edge k+(i+1)*(SETTLE+1).
  - done is high after edge k+2^N_IN*(SETTLE+1); this is edge k+24 for the defaults.
- start while busy=1 is ignored; no queuing.
- err_count cannot overflow, since its maximum value is 2^N_IN and it is N_IN+1 bits wide.
- Reset mid-run aborts the run; all results are lost. The next run requires a fresh start after rst_n returns high.
- Result outputs remain stable from done until the next accepted start.

Test Plan:
1. Golden response: a model drives dut_y=EXP_TT[vec_out]; pulse start at edge k.
   - Required: vec_out steps 0..7, each held 3 cycles.
   - Required: done pulses one cycle after edge k+24, with pass=1, err_count=0, first_fail_valid=0.
2. Stuck-at-0: dut_y=0 for the whole run.
   - Required: err_count=3, first_fail_valid=1, first_fail_idx=0, pass=0.
3. Single fault: golden response except inverted at vector 5.
   - Required: err_count=1, first_fail_idx=5, pass=0.
4. start held high throughout a golden run.
   - Required: start during RUN is ignored.
   - Required: a second run starts at the DONE edge, with busy=1 on the next cycle, vec_out=0, and results cleared.
5. Reset mid-run: drop rst_n while vec_out=3, between edges.
   - Required: all outputs go to reset values immediately.
   - Required: after rst_n returns high, a new start gives the same results as test 1.
6. dut_y=X for the whole run.
   - Required: err_count=8, first_fail_idx=0, pass=0.
